// File: rtl/home_inventory_pkg.sv
// Shared constants and helpers for the home-inventory sampling blocks
// (framer, event detector, timestamped peripherals).
package home_inventory_pkg;
  localparam int NUM_CH   = 8;
  localparam int CH_IDX_W = 3;
  localparam int SAMPLE_W = 32;
  localparam int TS_W     = 32;

  typedef enum logic {ST_IDLE, ST_COLLECT} frm_st_e;

  // Saturating increment: statistics stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/home_inventory_ts_counter.sv
// Free-running timestamp: prescaler divides clk by TS_DIV, 32-bit counter wraps.
module home_inventory_ts_counter
  import home_inventory_pkg::*;
#(
  parameter int TS_DIV = 1
) (
  input  logic            clk,
  input  logic            rst,
  output logic [TS_W-1:0] ts
);
  localparam logic [15:0] DIV_M1 = 16'(TS_DIV - 1);

  logic [15:0] pre;

  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
      ts  <= '0;
    end else if (pre == DIV_M1) begin
      pre <= '0;
      ts  <= ts + 32'd1;
    end else begin
      pre <= pre + 16'd1;
    end
  end
endmodule

// File: rtl/home_inventory_sample_framer.sv
// Collects ordered ch0..ch7 words into a timestamped frame and strobes it to
// the event detector; tracks committed/dropped frame statistics.
module home_inventory_sample_framer
  import home_inventory_pkg::*;
#(
  parameter int TS_DIV        = 1,
  parameter int FRAME_TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                clear_stats,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH_IDX_W-1:0] in_ch,
  input  logic [SAMPLE_W-1:0] in_data,
  output logic                sample_valid,
  output logic [TS_W-1:0]     ts_now,
  output logic [SAMPLE_W-1:0] sample_ch0,
  output logic [SAMPLE_W-1:0] sample_ch1,
  output logic [SAMPLE_W-1:0] sample_ch2,
  output logic [SAMPLE_W-1:0] sample_ch3,
  output logic [SAMPLE_W-1:0] sample_ch4,
  output logic [SAMPLE_W-1:0] sample_ch5,
  output logic [SAMPLE_W-1:0] sample_ch6,
  output logic [SAMPLE_W-1:0] sample_ch7,
  output logic [31:0]         frame_count,
  output logic [31:0]         drop_count,
  output logic                seq_err,
  output logic                busy
);
  localparam logic [15:0]         TO_M1   = 16'(FRAME_TIMEOUT - 1);
  localparam logic [CH_IDX_W-1:0] LAST_CH = CH_IDX_W'(NUM_CH - 1);

  logic [TS_W-1:0]     ts, ts_shadow;
  logic [SAMPLE_W-1:0] shadow   [NUM_CH-1];
  logic [SAMPLE_W-1:0] sample_q [NUM_CH];
  logic [CH_IDX_W-1:0] exp_ch, exp_nxt;
  frm_st_e             st, st_nxt;
  logic [15:0]         idle_cnt, idle_nxt;
  logic                commit, drop, seq_set, ts_cap, wr_sh;
  logic [31:0]         frame_cnt_q, drop_cnt_q;

  home_inventory_ts_counter #(.TS_DIV(TS_DIV)) u_ts (.clk(clk), .rst(rst), .ts(ts));

  assign in_ready    = enable;
  assign busy        = (st == ST_COLLECT);
  assign frame_count = frame_cnt_q;
  assign drop_count  = drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= ST_IDLE;
      exp_ch   <= '0;
      idle_cnt <= '0;
    end else begin
      st       <= st_nxt;
      exp_ch   <= exp_nxt;
      idle_cnt <= idle_nxt;
    end
  end

  // A restart after a sequence error always arrives on ch0, so the shadow slot
  // to write is in_ch in both the in-order and the restart case.
  always_comb begin
    exp_nxt  = exp_ch;
    idle_nxt = idle_cnt;
    commit   = 1'b0;
    drop     = 1'b0;
    seq_set  = 1'b0;
    ts_cap   = 1'b0;
    wr_sh    = 1'b0;
    if (!enable) begin
      drop     = (exp_ch != '0);
      exp_nxt  = '0;
      idle_nxt = '0;
    end else if (in_valid) begin
      idle_nxt = '0;
      if (in_ch == exp_ch) begin
        ts_cap = (exp_ch == '0);
        if (exp_ch == LAST_CH) begin
          commit  = 1'b1;
          exp_nxt = '0;
        end else begin
          wr_sh   = 1'b1;
          exp_nxt = exp_ch + 3'd1;
        end
      end else begin
        seq_set = 1'b1;
        drop    = (exp_ch != '0);
        if (in_ch == '0) begin
          ts_cap  = 1'b1;
          wr_sh   = 1'b1;
          exp_nxt = 3'd1;
        end else begin
          exp_nxt = '0;
        end
      end
    end else if (exp_ch != '0) begin
      if (idle_cnt == TO_M1) begin
        drop     = 1'b1;
        exp_nxt  = '0;
        idle_nxt = '0;
      end else begin
        idle_nxt = idle_cnt + 16'd1;
      end
    end
    st_nxt = (exp_nxt != '0) ? ST_COLLECT : ST_IDLE;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    if (i < NUM_CH - 1) begin : g_sh
      always_ff @(posedge clk) begin
        if (rst)                                       shadow[i] <= '0;
        else if (wr_sh && in_ch == CH_IDX_W'(i))       shadow[i] <= in_data;
      end
      always_ff @(posedge clk) begin
        if (rst)         sample_q[i] <= '0;
        else if (commit) sample_q[i] <= shadow[i];
      end
    end else begin : g_last
      always_ff @(posedge clk) begin
        if (rst)         sample_q[i] <= '0;
        else if (commit) sample_q[i] <= in_data;
      end
    end
  end

  assign sample_ch0 = sample_q[0];
  assign sample_ch1 = sample_q[1];
  assign sample_ch2 = sample_q[2];
  assign sample_ch3 = sample_q[3];
  assign sample_ch4 = sample_q[4];
  assign sample_ch5 = sample_q[5];
  assign sample_ch6 = sample_q[6];
  assign sample_ch7 = sample_q[7];

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_shadow    <= '0;
      ts_now       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= commit;
      if (ts_cap) ts_shadow <= ts;
      if (commit) ts_now    <= ts_shadow;
    end
  end

  // Clear wins over a same-cycle increment or error.
  always_ff @(posedge clk) begin
    if (rst || clear_stats) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      seq_err     <= 1'b0;
    end else begin
      if (commit)  frame_cnt_q <= sat_inc32(frame_cnt_q);
      if (drop)    drop_cnt_q  <= sat_inc32(drop_cnt_q);
      if (seq_set) seq_err     <= 1'b1;
    end
  end
endmodule

// File: doc/home_inventory_sample_framer.md
Name: home_inventory_sample_framer

Overview:
- Producer side of the per-channel sample interface: `sample_valid`, `ts_now` and `sample_ch0..7` feed the event detector directly.
- Accepts an ordered stream of tagged channel words (ch0..ch7) from the ADC capture pipeline or a bring-up stub, using a valid/ready handshake.
- Assembles each set of eight words into one frame, stamps it from a free-running prescaled timestamp counter, and emits it as a single-cycle `sample_valid` strobe.
- Keeps frame and drop statistics for firmware.

Parameters:
- TS_DIV, 1, clk cycles per timestamp tick (legal range 1..65535).
- FRAME_TIMEOUT, 1023, idle cycles allowed between accepted words inside a partial frame before it is aborted (legal 1..65535).

Ports:
- clk  input  1  clock.
- rst  input  1  reset: synchronous, active-high.
- enable  input  1  framer enable (register block).
- clear_stats  input  1  write-1-to-pulse; clears the statistics.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  framer can accept a word.
- in_ch  input  3  channel tag of the word.
- in_data  input  32  channel sample value.
- sample_valid  output  1  one-cycle frame strobe to the detector.
- ts_now  output  32  frame timestamp.
- sample_ch0..sample_ch7  output  32 each  committed frame samples.
- frame_count  output  32  saturating count of committed frames.
- drop_count  output  32  saturating count of aborted partial frames.
- seq_err  output  1  sticky flag: channel out of order.
- busy  output  1  partial frame in progress (exp_ch != 0).

Behaviour:
- Reset values: all outputs 0, exp_ch=0, shadow registers 0, timestamp counter 0, prescaler 0.
- Timestamp counter:
  - 32-bit, runs regardless of `enable`.
  - Increments when the prescaler reaches TS_DIV-1; the prescaler then returns to 0.
  - Wraps 0xFFFFFFFF->0. Wrap is permitted because detector deltas are modulo 2^32.
- Handshake:
  - in_ready = enable (combinational). A word is accepted when in_valid && in_ready.
  - No back-pressure otherwise: the framer accepts one word per cycle back-to-back, including the cycle in which a frame commits.
- Word accepted with in_ch == exp_ch:
  - If exp_ch==0: ts_shadow <= current timestamp counter value.
  - If exp_ch<7: shadow[exp_ch] <= in_data; exp_ch <= exp_ch+1.
  - If exp_ch==7 (commit):
    - sample_ch0..6 <= shadow[0..6]; sample_ch7 <= in_data; ts_now <= ts_shadow.
    - sample_valid=1 in the next cycle only.
    - frame_count saturating-increments; exp_ch <= 0.
- Word accepted with in_ch != exp_ch (sequence error):
  - seq_err <= 1.
  - If exp_ch != 0: the partial frame is discarded and drop_count saturating-increments.
  - If in_ch == 0: the word starts a new frame (ts_shadow captured, shadow[0] written, exp_ch <= 1).
  - Otherwise exp_ch <= 0.
- Latency: last word accepted in cycle N -> sample_valid, sample_ch*, ts_now updated at N+1.
- Output stability: sample_ch* and ts_now hold until the next commit.
- Timeout:
  - Idle counter resets on every accepted word and counts while exp_ch != 0 and no word is accepted.
  - On reaching FRAME_TIMEOUT: partial frame aborted, drop_count++, exp_ch <= 0.
- Enable low while exp_ch != 0: the partial frame is aborted on the first cycle enable is low (drop_count++, exp_ch <= 0). Committed outputs are untouched.
- clear_stats:
  - Clears frame_count, drop_count and seq_err.
  - A clear wins over a same-cycle increment.
  - Does not affect framing or the timestamp.
- Monotonicity: ts_now across successive frames is non-decreasing modulo wrap. Equal ts_now values are legal when TS_DIV exceeds the frame period.
- Saturation: both counters hold at 0xFFFFFFFF.
- busy = (exp_ch != 0), registered state.
- States:
  - IDLE (exp_ch=0).
  - COLLECT (exp_ch 1..7).
  - The commit strobe is a registered pulse, not a state.
  - Transitions are exactly as described above.

Decomposition:
- Shared package home_inventory_pkg:
  - Constants NUM_CH=8, CH_IDX_W=3, SAMPLE_W=32, TS_W=32.
  - sat_inc32 function, shared with the event detector.
- Sub-module home_inventory_ts_counter:
  - Prescaler plus 32-bit wrap counter.
  - Parameter TS_DIV; output ts.
  - Reusable by other timestamped blocks.

Test Plan:
- Ordered frame: TS_DIV=1, enable=1, 8 back-to-back words ch0..7 with data 0x100+ch, ch0 accepted when ts=20 -> one sample_valid pulse at the cycle after ch7; sample_ch3=0x103; ts_now=20; frame_count=1.
- Out-of-order recovery: ch0, ch1, ch0, then ch1..7 -> seq_err=1, drop_count=1; frame commits with the second ch0 data and its timestamp; frame_count=1.
- Timeout: FRAME_TIMEOUT=4, send ch0..2 then idle 4 cycles -> busy falls, drop_count=1, no sample_valid; a following full frame commits normally.
- Enable drop mid-frame: ch0..4, enable=0 for one cycle, then ch5 with enable=1 -> drop_count=1, seq_err=1 (expected ch0), no commit; prior sample_ch* values unchanged.
- Prescale and wrap: TS_DIV=3, timestamp preloaded near 0xFFFFFFFE via force -> ts increments every 3 cycles and wraps to 0; ts_now of consecutive frames reflects the wrap.
- Clear collision: clear_stats asserted in the same cycle as a commit -> frame_count=0 afterwards; sample_valid still pulses.
